// File: rtl/deser_rr_sched.sv
// deser_rr_sched: round-robin owner of a single shared deserializer.
// One requesting serial channel is granted for exactly one WIDTH-bit word.
// Its bits are steered into the deserializer, and the resulting word is
// returned tagged with the channel index. If the deserializer stays silent
// for too long, a timeout pulse is raised instead.
//
// Handshake semantics (all signals sampled on posedge clk_i):
//   req_i[k]        level request; looked at only while idle, no ack other than gnt_o.
//   gnt_o[k]        registered one-hot owner; held until WIDTH valid bits have passed.
//   data_val_i[k]   qualifies data_i[k] for one cycle; gaps are allowed, no backpressure.
//   ser_data_val_o  combinational copy of the owner's data_val_i while streaming, else 0.
//   deser_data_val_i  one-cycle word strobe from the deserializer; honoured only while waiting.
//   word_val_o / timeout_o  single-cycle, mutually exclusive completion pulses; no backpressure.
module deser_rr_sched #(
  parameter int N       = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 8,
  localparam int CH_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     data_i,
  input  logic [N-1:0]     data_val_i,
  output logic [N-1:0]     gnt_o,
  output logic             ser_data_o,
  output logic             ser_data_val_o,
  input  logic [WIDTH-1:0] deser_data_i,
  input  logic             deser_data_val_i,
  output logic [WIDTH-1:0] word_o,
  output logic [CH_W-1:0]  word_chan_o,
  output logic             word_val_o,
  output logic             timeout_o,
  output logic [1:0]       state_dbg_o
);

  localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CH_W-1:0] g_idx;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] ptr_inc;
  logic [BC_W-1:0] bit_cnt;
  logic [WC_W-1:0] wait_cnt;

  logic            pick_found;
  logic [CH_W-1:0] pick_idx;
  logic [N-1:0]    pick_onehot;
  logic            fwd_last;
  logic            cap;
  logic            tmo;

  assign state_dbg_o = state_q;
  assign ptr_inc     = (g_idx == CH_W'(N - 1)) ? '0 : g_idx + CH_W'(1);

  // Round-robin pick: first requester at or after ptr, wrapping mod N.
  always_comb begin
    int              cand;
    logic [CH_W-1:0] cand_idx;
    pick_found  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = CH_W'(cand);
      if (!pick_found && req_i[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
    pick_onehot[pick_idx] = pick_found;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (srst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state, serial steering mux and completion strobes.
  always_comb begin
    state_d        = state_q;
    ser_data_o     = 1'b0;
    ser_data_val_o = 1'b0;
    fwd_last       = 1'b0;
    cap            = 1'b0;
    tmo            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        ser_data_o     = data_i[g_idx];
        ser_data_val_o = data_val_i[g_idx];
        if (data_val_i[g_idx] && (bit_cnt == BC_W'(WIDTH - 1))) begin
          fwd_last = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A word arriving on the last allowed cycle beats the timeout.
        if (deser_data_val_i) begin
          cap     = 1'b1;
          state_d = ST_IDLE;
        end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
          tmo     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant, counters, pointer and captured word.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      gnt_o       <= '0;
      g_idx       <= '0;
      ptr         <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      word_o      <= '0;
      word_chan_o <= '0;
      word_val_o  <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      word_val_o <= cap;
      timeout_o  <= tmo;
      case (state_q)
        ST_IDLE: begin
          bit_cnt  <= '0;
          wait_cnt <= '0;
          if (pick_found) begin
            gnt_o <= pick_onehot;
            g_idx <= pick_idx;
          end
        end
        ST_STREAM: begin
          if (ser_data_val_o) begin
            if (fwd_last) begin
              bit_cnt <= '0;
              gnt_o   <= '0;
            end else begin
              bit_cnt <= bit_cnt + BC_W'(1);
            end
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + WC_W'(1);
          if (cap || tmo) begin
            wait_cnt <= '0;
            ptr      <= ptr_inc;
          end
          if (cap) begin
            word_o      <= deser_data_i;
            word_chan_o <= g_idx;
          end
        end
        default: begin
          gnt_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deser_rr_sched.sv
// tb_deser_rr_sched: directed bench for deser_rr_sched with a behavioural
// MSB-first deserializer, per-channel bit sources and a word-level scoreboard.
module tb_deser_rr_sched;
  localparam int N       = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int CH_W    = $clog2(N);

  logic             clk  = 1'b0;
  logic             srst = 1'b1;
  logic [N-1:0]     req_i = '0;
  logic [N-1:0]     data_i = '0;
  logic [N-1:0]     data_val_i = '0;
  logic [N-1:0]     gnt_o;
  logic             ser_data_o;
  logic             ser_data_val_o;
  logic [WIDTH-1:0] deser_data = '0;
  logic             deser_data_val = 1'b0;
  logic [WIDTH-1:0] word_o;
  logic [CH_W-1:0]  word_chan_o;
  logic             word_val_o;
  logic             timeout_o;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard and model state.
  logic [CH_W+WIDTH-1:0] exp_q[$];
  bit                    exp_bit_q[$];
  int                    exp_to = 0;
  int                    mptr = 0;
  int                    got_chan_q[$];
  int                    wv_cnt = 0, to_cnt = 0, fwd_cnt = 0;
  int                    cyc = 0, fall_cyc = 0, to_cyc = 0, dv_cyc = 0;
  logic [N-1:0]          prev_gnt = '0;

  // Source control.
  bit           ch_bits[N][$];
  logic [N-1:0] gap_en = '0, noise_en = '0, gap_ph = '1;

  // Deserializer model control.
  bit               deser_mute = 1'b0;
  int               deser_extra = 0;
  int               ds_cnt = 0, ds_pend = 0;
  logic [WIDTH-1:0] ds_sh = '0, ds_word = '0;

  deser_rr_sched #(.N(N), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i            (clk),
    .srst_i           (srst),
    .req_i            (req_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .gnt_o            (gnt_o),
    .ser_data_o       (ser_data_o),
    .ser_data_val_o   (ser_data_val_o),
    .deser_data_i     (deser_data),
    .deser_data_val_i (deser_data_val),
    .word_o           (word_o),
    .word_chan_o      (word_chan_o),
    .word_val_o       (word_val_o),
    .timeout_o        (timeout_o),
    .state_dbg_o      (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Behavioural deserializer: MSB-first shift, word strobe after WIDTH bits,
  // optionally delayed by deser_extra cycles or suppressed entirely.
  always @(posedge clk) begin
    if (srst) begin
      ds_cnt <= 0; ds_pend <= 0; deser_data_val <= 1'b0; deser_data <= '0; ds_sh <= '0;
    end else begin
      deser_data_val <= 1'b0;
      if (ser_data_val_o) begin
        ds_sh <= {ds_sh[WIDTH-2:0], ser_data_o};
        if (ds_cnt == WIDTH - 1) begin
          ds_cnt <= 0;
          if (deser_extra == 0) begin
            if (!deser_mute) begin
              deser_data_val <= 1'b1;
              deser_data     <= {ds_sh[WIDTH-2:0], ser_data_o};
            end
          end else begin
            ds_word <= {ds_sh[WIDTH-2:0], ser_data_o};
            ds_pend <= deser_extra;
          end
        end else begin
          ds_cnt <= ds_cnt + 1;
        end
      end
      if (ds_pend == 1) begin
        if (!deser_mute) begin
          deser_data_val <= 1'b1;
          deser_data     <= ds_word;
        end
        ds_pend <= 0;
      end else if (ds_pend > 1) begin
        ds_pend <= ds_pend - 1;
      end
    end
  end

  // Channel sources: a granted channel sends its queued bits; noisy channels
  // assert valid with random bits whenever they are not granted.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++) begin
      data_val_i[k] = 1'b0;
      data_i[k]     = 1'($urandom_range(0, 1));
      if (gnt_o[k] && ch_bits[k].size() > 0) begin
        if (!gap_en[k] || gap_ph[k]) begin
          data_val_i[k] = 1'b1;
          data_i[k]     = ch_bits[k].pop_front();
        end
        gap_ph[k] = ~gap_ph[k];
      end else if (!gnt_o[k] && noise_en[k]) begin
        data_val_i[k] = 1'b1;
      end
      if (!gnt_o[k]) gap_ph[k] = 1'b1;
    end
  end

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    cyc++;
    if (!srst) begin
      check("gnt_onehot0", 32'($onehot0(gnt_o)), 32'd1);
      check("val_tmo_excl", 32'(word_val_o & timeout_o), 32'd0);
      if (ser_data_val_o) begin
        fwd_cnt++;
        check("bit_expected", 32'(exp_bit_q.size() != 0), 32'd1);
        if (exp_bit_q.size() != 0) check("ser_bit", 32'(ser_data_o), 32'(exp_bit_q.pop_front()));
      end
      if (word_val_o) begin
        wv_cnt++;
        got_chan_q.push_back(int'(word_chan_o));
        check("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("word_chan_data", 32'({word_chan_o, word_o}), 32'(exp_q.pop_front()));
      end
      if (timeout_o) begin
        to_cnt++;
        to_cyc = cyc;
        check("timeout_expected", 32'(exp_to > 0), 32'd1);
        if (exp_to > 0) exp_to--;
      end
      if (prev_gnt != '0 && gnt_o == '0) fall_cyc = cyc;
      if (deser_data_val) dv_cyc = cyc;
      prev_gnt = gnt_o;
    end else begin
      prev_gnt = '0;
    end
  end

  // Model: round-robin choice from a pointer.
  function automatic int rr_pick(input logic [N-1:0] req, input int p);
    int c;
    for (int i = 0; i < N; i++) begin
      c = (p + i) % N;
      if (((req >> c) & {{(N-1){1'b0}}, 1'b1}) != '0) return c;
    end
    return 0;
  endfunction

  // Queue one word for channel c: source bits, expected serial bits, and
  // either an expected tagged word or an expected timeout.
  task automatic expect_word(input int c, input logic [WIDTH-1:0] w, input bit to);
    for (int b = WIDTH - 1; b >= 0; b--) begin
      exp_bit_q.push_back(w[b]);
      ch_bits[c].push_back(w[b]);
    end
    if (to) exp_to++;
    else exp_q.push_back({CH_W'(c), w});
    mptr = (c + 1) % N;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    srst = 1'b1; req_i = '0;
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;
    mptr = 0;
  endtask

  task automatic req_check(input logic [N-1:0] r, input logic [N-1:0] g_exp, input string name);
    @(posedge clk); #1 req_i = r;
    @(negedge clk); check({name, "_gnt_pre"}, 32'(gnt_o), 32'd0);
    @(negedge clk); check({name, "_gnt"}, 32'(gnt_o), 32'(g_exp));
    req_i = '0;
  endtask

  task automatic wait_wv(input int target, input int budget, input string name);
    int n = 0;
    while (wv_cnt < target && n < budget) begin @(negedge clk); n++; end
    check(name, 32'(wv_cnt >= target), 32'd1);
  endtask

  task automatic wait_to(input int target, input int budget, input string name);
    int n = 0;
    while (to_cnt < target && n < budget) begin @(negedge clk); n++; end
    check(name, 32'(to_cnt >= target), 32'd1);
  endtask

  task automatic wait_fwd(input int target, input int budget, input string name);
    int n = 0;
    while (fwd_cnt < target && n < budget) begin @(negedge clk); n++; end
    check(name, 32'(fwd_cnt >= target), 32'd1);
  endtask

  // Directed scenarios.
  initial begin
    int base, tbase, fbase;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [WIDTH-1:0] w1234;

    // Reset values.
    do_reset();
    @(negedge clk);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_word", 32'(word_o), 32'd0);
    check("rst_chan", 32'(word_chan_o), 32'd0);
    check("rst_wv", 32'(word_val_o), 32'd0);
    check("rst_tmo", 32'(timeout_o), 32'd0);
    check("rst_ser_val", 32'(ser_data_val_o), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Single word from channel 0.
    base = wv_cnt;
    expect_word(rr_pick(4'b0001, mptr), 16'hA5C3, 1'b0);
    req_check(4'b0001, 4'b0001, "t1");
    wait_wv(base + 1, 60, "t1_word_arrives");
    repeat (10) @(negedge clk);
    check("t1_once", 32'(wv_cnt - base), 32'd1);
    check("t1_word", 32'(word_o), 32'hA5C3);
    check("t1_chan", 32'(word_chan_o), 32'd0);

    // All channels requesting continuously, starting from pointer 0.
    do_reset();
    got_chan_q.delete();
    base = wv_cnt;
    for (int i = 0; i < 5; i++) begin
      int c;
      c = rr_pick(4'b1111, mptr);
      expect_word(c, WIDTH'(16'h1000 + c), 1'b0);
    end
    @(posedge clk); #1 req_i = 4'b1111;
    wait_wv(base + 4, 300, "t2_four_words");
    @(posedge clk); #1 req_i = '0;
    wait_wv(base + 5, 100, "t2_fifth_word");
    for (int i = 0; i < 5; i++) begin
      if (i < got_chan_q.size()) check($sformatf("t2_order%0d", i), 32'(got_chan_q[i]), 32'(exp_order[i]));
      else check($sformatf("t2_order%0d_missing", i), 32'(got_chan_q.size()), 32'(i + 1));
    end

    // Channel 2 with gapped valid, channel 1 injecting noise.
    base = wv_cnt;
    gap_en[2] = 1'b1; noise_en[1] = 1'b1;
    expect_word(rr_pick(4'b0100, mptr), 16'h3C96, 1'b0);
    req_check(4'b0100, 4'b0100, "t3");
    wait_wv(base + 1, 120, "t3_word_arrives");
    gap_en = '0; noise_en = '0;
    check("t3_word", 32'(word_o), 32'h3C96);
    check("t3_chan", 32'(word_chan_o), 32'd2);

    // Silent deserializer: channel 3 times out, pointer wraps to 0.
    base = wv_cnt; tbase = to_cnt;
    deser_mute = 1'b1;
    expect_word(rr_pick(4'b1000, mptr), 16'h5A5A, 1'b1);
    req_check(4'b1000, 4'b1000, "t4");
    wait_to(tbase + 1, 80, "t4_timeout_arrives");
    check("t4_to_latency", 32'(to_cyc - fall_cyc), 32'd8);
    check("t4_word_kept", 32'(word_o), 32'h3C96);
    check("t4_no_word", 32'(wv_cnt - base), 32'd0);
    deser_mute = 1'b0;
    expect_word(rr_pick(4'b1001, mptr), 16'h0F0F, 1'b0);
    req_check(4'b1001, 4'b0001, "t4_next");
    wait_wv(base + 1, 60, "t4_next_word");
    check("t4_next_chan", 32'(word_chan_o), 32'd0);

    // Reset after 7 bits of channel 1.
    base = wv_cnt; tbase = to_cnt; fbase = fwd_cnt;
    w1234 = 16'h1234;
    for (int b = WIDTH - 1; b > WIDTH - 8; b--) begin
      exp_bit_q.push_back(w1234[b]);
      ch_bits[1].push_back(w1234[b]);
    end
    req_check(4'b0010, 4'b0010, "t5");
    wait_fwd(fbase + 7, 60, "t5_seven_bits");
    @(posedge clk); #2 srst = 1'b1;
    @(posedge clk); #2 srst = 1'b0;
    mptr = 0;
    @(negedge clk);
    check("t5_gnt_cleared", 32'(gnt_o), 32'd0);
    check("t5_state_idle", 32'(state_dbg), 32'd0);
    repeat (30) @(negedge clk);
    check("t5_no_word", 32'(wv_cnt - base), 32'd0);
    check("t5_no_tmo", 32'(to_cnt - tbase), 32'd0);
    check("t5_bits_drained", 32'(exp_bit_q.size()), 32'd0);
    expect_word(rr_pick(4'b0010, mptr), 16'hFFFF, 1'b0);
    req_check(4'b0010, 4'b0010, "t5_after");
    wait_wv(base + 1, 60, "t5_word_arrives");
    check("t5_word", 32'(word_o), 32'hFFFF);
    check("t5_chan", 32'(word_chan_o), 32'd1);

    // Deserializer valid on the last allowed WAIT cycle: valid wins.
    base = wv_cnt; tbase = to_cnt;
    deser_extra = 7;
    expect_word(rr_pick(4'b0001, mptr), 16'hBEEF, 1'b0);
    req_check(4'b0001, 4'b0001, "t6");
    wait_wv(base + 1, 80, "t6_word_arrives");
    repeat (4) @(negedge clk);
    check("t6_dv_at_last_wait", 32'(dv_cyc - fall_cyc), 32'd7);
    check("t6_no_tmo", 32'(to_cnt - tbase), 32'd0);
    check("t6_word", 32'(word_o), 32'hBEEF);
    deser_extra = 0;

    // Everything the model expected was observed.
    repeat (5) @(negedge clk);
    check("end_words_left", 32'(exp_q.size()), 32'd0);
    check("end_bits_left", 32'(exp_bit_q.size()), 32'd0);
    check("end_tmo_left", 32'(exp_to), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
